// File: rtl/ac97_pkg.sv
// Shared constants for the AC97 frame transmitter: frame geometry, init FSM states and command ROM.
// The init FSM and ROM are only used when AC97_CMD_INIT_EN is defined.
package ac97_pkg;

    localparam int unsigned SLOT0_END   = 15;
    localparam int unsigned SLOT1_END   = 35;
    localparam int unsigned SLOT2_END   = 55;
    localparam int unsigned SLOT3_END   = 75;
    localparam int unsigned SLOT4_END   = 95;
    localparam int unsigned FRAME_BITS  = 256;
    localparam int unsigned FIFO_RD_POS = 250;

    localparam int unsigned NUM_CMDS = 3;

    typedef logic [1:0] init_state_t;
    localparam init_state_t ST_WAIT_READY = 2'd0;
    localparam init_state_t ST_SEND       = 2'd1;
    localparam init_state_t ST_DONE       = 2'd2;

    function automatic logic [6:0] cmd_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return 7'h02;
            2'd1:    return 7'h04;
            default: return 7'h18;
        endcase
    endfunction

    function automatic logic [15:0] cmd_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'h0000;
            2'd1:    return 16'h0000;
            default: return 16'h0808;
        endcase
    endfunction

endpackage

// File: rtl/ac97_cmd_seq.sv
// Codec register init sequencer: waits for codec ready, then issues one write per frame from the ROM.
// Instantiated by ac97_frame_tx only when AC97_CMD_INIT_EN is defined.
module ac97_cmd_seq
    import ac97_pkg::*;
(
    input  logic        bit_clk_i,
    input  logic        rst_i,
    input  logic        frame_end_i,
    input  logic        codec_ready_i,
    output logic        cmd_valid_o,
    output logic [19:0] cmd_addr_o,
    output logic [19:0] cmd_data_o
);

    init_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (frame_end_i) begin
            case (state_q)
                ST_WAIT_READY: begin
                    if (codec_ready_i) begin
                        state_d = ST_SEND;
                        idx_d   = 2'd0;
                    end
                end
                ST_SEND: begin
                    if (idx_q == 2'(NUM_CMDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bit_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_WAIT_READY;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign cmd_valid_o = (state_q == ST_SEND);
    assign cmd_addr_o  = {1'b0, cmd_reg(idx_q), 12'b0};
    assign cmd_data_o  = {cmd_val(idx_q), 4'b0};

endmodule

// File: rtl/ac97_frame_tx.sv
// AC97 output frame serializer: one FIFO sample per frame, sent on Slots 3 and 4.
// Define AC97_CMD_INIT_EN to add the codec register init sequence on Slots 1/2.
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 20
) (
    input  logic                    bit_clk,
    input  logic                    rst,
    output logic                    sync,
    output logic                    sdata_out,
    input  logic                    sdata_in,
    input  logic [SAMPLE_WIDTH-1:0] fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam logic [7:0] PosSlot1 = 8'(SLOT0_END + 1);
    localparam logic [7:0] PosSlot2 = 8'(SLOT1_END + 1);
    localparam logic [7:0] PosSlot3 = 8'(SLOT2_END + 1);
    localparam logic [7:0] PosSlot4 = 8'(SLOT3_END + 1);
    localparam logic [7:0] PosSlot5 = 8'(SLOT4_END + 1);
    localparam logic [7:0] PosRd    = 8'(FIFO_RD_POS);
    localparam logic [7:0] PosLatch = 8'(FIFO_RD_POS + 2);
    localparam logic [7:0] PosLast  = 8'(FRAME_BITS - 1);

    logic [7:0]  pos_q;
    logic [19:0] shift_q, shift_d;
    logic [19:0] hold_q;
    logic        sync_q, sdata_q, sdata_d, rd_en_q, fs_q, ur_q, pend_q;

    logic        cmd_valid;
    logic [19:0] cmd_addr, cmd_data;

`ifdef AC97_CMD_INIT_EN
    logic codec_ready_q;

    always_ff @(posedge bit_clk or posedge rst) begin
        if (rst) begin
            codec_ready_q <= 1'b0;
        end else if (pos_q == 8'd2) begin
            codec_ready_q <= sdata_in;
        end
    end

    ac97_cmd_seq u_cmd_seq (
        .bit_clk_i     (bit_clk),
        .rst_i         (rst),
        .frame_end_i   (pos_q == PosLast),
        .codec_ready_i (codec_ready_q),
        .cmd_valid_o   (cmd_valid),
        .cmd_addr_o    (cmd_addr),
        .cmd_data_o    (cmd_data)
    );
`else
    logic unused_sdata_in;
    assign unused_sdata_in = sdata_in;
    assign cmd_valid       = 1'b0;
    assign cmd_addr        = '0;
    assign cmd_data        = '0;
`endif

    logic [15:0] tag;
    logic [19:0] sample_ext;
    assign tag        = {1'b1, cmd_valid, cmd_valid, 2'b11, 11'b0};
    assign sample_ext = 20'(fifo_dout) << (20 - SAMPLE_WIDTH);

    // Each slot start reloads the shift register; slots 5..12 shift out zeros.
    always_comb begin
        logic [19:0] word;
        logic        load;
        word = '0;
        load = 1'b1;
        if (pos_q == 8'd0)          word = {tag, 4'b0};
        else if (pos_q == PosSlot1) word = cmd_valid ? cmd_addr : 20'd0;
        else if (pos_q == PosSlot2) word = cmd_valid ? cmd_data : 20'd0;
        else if (pos_q == PosSlot3) word = hold_q;
        else if (pos_q == PosSlot4) word = hold_q;
        else if (pos_q == PosSlot5) word = '0;
        else                        load = 1'b0;

        if (load) begin
            sdata_d = word[19];
            shift_d = {word[18:0], 1'b0};
        end else begin
            sdata_d = shift_q[19];
            shift_d = {shift_q[18:0], 1'b0};
        end
    end

    always_ff @(posedge bit_clk or posedge rst) begin
        if (rst) begin
            pos_q   <= 8'd0;
            shift_q <= '0;
            hold_q  <= '0;
            sync_q  <= 1'b0;
            sdata_q <= 1'b0;
            rd_en_q <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pos_q   <= pos_q + 8'd1;
            shift_q <= shift_d;
            sdata_q <= sdata_d;
            sync_q  <= (pos_q <= 8'(SLOT0_END));
            fs_q    <= (pos_q == 8'd0);
            rd_en_q <= (pos_q == PosRd) && !fifo_empty;
            ur_q    <= (pos_q == PosRd) && fifo_empty;
            // FIFO data is valid the cycle after the pop, i.e. during position 251.
            pend_q  <= rd_en_q;
            if ((pos_q == PosLatch) && pend_q) begin
                hold_q <= sample_ext;
            end
        end
    end

    assign sync        = sync_q;
    assign sdata_out   = sdata_q;
    assign fifo_rd_en  = rd_en_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Self-checking bench for ac97_frame_tx: codec-side frame decoder, FIFO model and expected frame contents.
// Honours AC97_CMD_INIT_EN to expect the init command frames.
module tb_ac97_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync, sdata_out, sdata_in, fifo_empty, fifo_rd_en, frame_start, underrun;
    logic [19:0] fifo_dout;
    logic        sdata_out_n;
    logic        n_unused_sync, n_unused_rd, n_unused_fs, n_unused_ur;

    always #5 clk = ~clk;

    ac97_frame_tx #(.SAMPLE_WIDTH(20)) dut (
        .bit_clk     (clk),
        .rst         (rst),
        .sync        (sync),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    ac97_frame_tx #(.SAMPLE_WIDTH(16)) dut_n (
        .bit_clk     (clk),
        .rst         (rst),
        .sync        (n_unused_sync),
        .sdata_out   (sdata_out_n),
        .sdata_in    (sdata_in),
        .fifo_dout   (16'h8001),
        .fifo_empty  (1'b0),
        .fifo_rd_en  (n_unused_rd),
        .frame_start (n_unused_fs),
        .underrun    (n_unused_ur)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: pop on read enable, data stays valid until the next pop.
    logic [19:0] fq[$];
    always @(negedge clk) begin
        if (!rst && fifo_rd_en && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    end

    // Codec-side decoder: frames are aligned on the rising edge of sync.
    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4, s3n;
        logic        rest_nz;
        int          bad, rd, ur;
        longint      start;
    } frame_t;

    frame_t       frames[$];
    int           mon_pos = -1;
    logic         sync_prev = 1'b0;
    logic [255:0] fb, fbn;
    int           bad_cnt, rd_cnt, ur_cnt;
    longint       cyc = 0, start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            mon_pos   = -1;
            sync_prev = 1'b0;
        end else begin
            if (sync && !sync_prev) begin
                mon_pos = 0; bad_cnt = 0; rd_cnt = 0; ur_cnt = 0; start_cyc = cyc;
            end else if (mon_pos >= 0) begin
                mon_pos++;
            end
            sync_prev = sync;
            if (mon_pos >= 0) begin
                fb[255-mon_pos]  = sdata_out;
                fbn[255-mon_pos] = sdata_out_n;
                if (sync !== (mon_pos < 16)) bad_cnt++;
                if (frame_start !== (mon_pos == 0)) bad_cnt++;
                if (mon_pos == 250) begin
                    rd_cnt += int'(fifo_rd_en);
                    ur_cnt += int'(underrun);
                end else if (fifo_rd_en || underrun) begin
                    bad_cnt++;
                end
                if (mon_pos == 255) begin
                    frames.push_back('{tag: fb[255:240], s1: fb[239:220], s2: fb[219:200],
                                       s3: fb[199:180], s4: fb[179:160], s3n: fbn[199:180],
                                       rest_nz: |fb[159:0], bad: bad_cnt, rd: rd_cnt,
                                       ur: ur_cnt, start: start_cyc});
                    mon_pos = -1;
                end
            end
        end
    end

    // Codec reports ready from frame 3 onward (counted from reset release).
    always @(negedge clk) begin
`ifdef AC97_CMD_INIT_EN
        sdata_in = (frames.size() >= 3);
`else
        sdata_in = 1'($urandom);
`endif
    end

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2;
    } cmd_vec_t;
    cmd_vec_t tbl[8];

    logic [19:0] smp[$];

    task automatic wait_frames(input int n);
        for (int i = 0; i < n * 256 + 1000 && frames.size() < n; i++) @(negedge clk);
        chk("frames_seen", 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input string ph, input int n, input int nf);
        logic [19:0] e3, e3n;
        logic [15:0] etag;
        logic [19:0] es1, es2;
        for (int k = 0; k < nf && k < frames.size(); k++) begin
            e3  = (k == 0) ? 20'd0 : smp[(k - 1 < n - 1) ? k - 1 : n - 1];
            e3n = (k == 0) ? 20'd0 : 20'h80010;
            if (k < 8) begin
                etag = tbl[k].tag; es1 = tbl[k].s1; es2 = tbl[k].s2;
            end else begin
                etag = 16'h9800; es1 = '0; es2 = '0;
            end
            chk($sformatf("%s f%0d tag", ph, k), 32'(frames[k].tag), 32'(etag));
            chk($sformatf("%s f%0d slot1", ph, k), 32'(frames[k].s1), 32'(es1));
            chk($sformatf("%s f%0d slot2", ph, k), 32'(frames[k].s2), 32'(es2));
            chk($sformatf("%s f%0d slot3", ph, k), 32'(frames[k].s3), 32'(e3));
            chk($sformatf("%s f%0d slot4", ph, k), 32'(frames[k].s4), 32'(e3));
            chk($sformatf("%s f%0d slot3_narrow", ph, k), 32'(frames[k].s3n), 32'(e3n));
            chk($sformatf("%s f%0d tail_zero", ph, k), 32'(frames[k].rest_nz), 32'd0);
            chk($sformatf("%s f%0d shape", ph, k), 32'(frames[k].bad), 32'd0);
            chk($sformatf("%s f%0d rd_en", ph, k), 32'(frames[k].rd), 32'(k < n));
            chk($sformatf("%s f%0d underrun", ph, k), 32'(frames[k].ur), 32'(k >= n));
            if (k > 0)
                chk($sformatf("%s f%0d period", ph, k),
                    32'(frames[k].start - frames[k-1].start), 32'd256);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tbl[k] = '{tag: 16'h9800, s1: 20'h0, s2: 20'h0};
`ifdef AC97_CMD_INIT_EN
        tbl[4] = '{tag: 16'hF800, s1: 20'h02000, s2: 20'h00000};
        tbl[5] = '{tag: 16'hF800, s1: 20'h04000, s2: 20'h00000};
        tbl[6] = '{tag: 16'hF800, s1: 20'h18000, s2: 20'h08080};
`endif

        // Phase A: ordered samples -50..50, then drain into underrun.
        for (int v = -50; v <= 50; v++) smp.push_back(20'(v));
        foreach (smp[i]) fq.push_back(smp[i]);
        fifo_empty = 1'b0;
        fifo_dout  = '0;
        sdata_in   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'({sync, sdata_out, fifo_rd_en, frame_start, underrun}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_sync_sdata", 32'({sync, sdata_out, frame_start}), 32'b111);
        wait_frames(115);
        check_frames("A", 101, 115);

        // Phase B: reset at p=120, then random samples.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (mon_pos == 120) break;
        end
        chk("reached_p120", 32'(mon_pos), 32'd120);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 32'({sync, sdata_out, fifo_rd_en, frame_start, underrun}), 32'd0);
        frames.delete();
        smp.delete();
        fq.delete();
        begin
            int n;
            n = $urandom_range(8, 3);
            for (int i = 0; i < n; i++) smp.push_back(20'($urandom));
            foreach (smp[i]) fq.push_back(smp[i]);
            repeat (3) @(negedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("restart_p0", 32'({sync, sdata_out, frame_start}), 32'b111);
            wait_frames(n + 6);
            check_frames("B", n, n + 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
